// File: rtl/ring_pkg.sv
// ring_pkg: ring flit type codes, command codes and FSM state type shared by the ring endpoints.
package ring_pkg;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;
  localparam logic [4:0] INST_REP_CMD = 5'b00111;
  localparam logic [4:0] INSTREQ_CMD = 5'b00110;
  localparam int CMD_HI = 12;
  localparam int CMD_LO = 8;
  typedef enum logic [1:0] {IDLE, RECV, DROP} dl_st_e;
endpackage

// File: rtl/ic_download.sv
// ic_download: assembles instruction-fill replies from the ring or local memory into one cache block.
module ic_download
  import ring_pkg::*;
#(
  parameter int FLIT_W   = 16,
  parameter int DATA_W   = 128,
  parameter int NUM_DATA = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_flit,
  input  logic [FLIT_W-1:0] flit,
  input  logic [1:0]        ctrl,
  input  logic              v_mem_rep,
  input  logic [DATA_W-1:0] mem_rep,
  output logic              ic_download_state,
  output logic              v_inst_4word,
  output logic [DATA_W-1:0] inst_4word
);
  localparam int CW = $clog2(NUM_DATA) + 1;
  dl_st_e            st_q;
  logic [CW-1:0]     cnt_q;
  logic              pend_q, v_q;
  logic [DATA_W-1:0] blk_q, blk_d, out_q;
  logic              take, is_head, is_body, is_tail, last, done, wr;
  assign take    = v_flit & ~pend_q;
  assign is_head = take && ctrl == FLIT_HEAD;
  assign is_body = take && ctrl == FLIT_BODY;
  assign is_tail = take && ctrl == FLIT_TAIL;
  assign last    = cnt_q == CW'(NUM_DATA - 1);
  assign done    = st_q == RECV && is_tail && last;
  assign wr      = st_q == RECV && (is_body || done);
  always_comb begin
    blk_d = blk_q;
    for (int i = 0; i < NUM_DATA; i++)
      if (wr && cnt_q == CW'(i)) blk_d[i*FLIT_W +: FLIT_W] = flit;
  end
  // A completed block that collides with a local reply waits in blk_q; the
  // ring is stalled meanwhile so blk_q cannot be overwritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      v_q    <= 1'b0;
      blk_q  <= '0;
      out_q  <= '0;
    end else begin
      v_q   <= pend_q | v_mem_rep | done;
      blk_q <= blk_d;
      if (pend_q) begin
        out_q  <= blk_q;
        pend_q <= 1'b0;
      end else if (v_mem_rep) begin
        out_q  <= mem_rep;
        pend_q <= done;
      end else if (done) out_q <= blk_d;
      if (is_head && st_q != DROP) begin
        st_q  <= flit[CMD_HI:CMD_LO] == INST_REP_CMD ? RECV : DROP;
        cnt_q <= '0;
      end else if (is_body && st_q == RECV) begin
        cnt_q <= cnt_q + 1'b1;
        if (last) st_q <= DROP;
      end else if (is_tail) st_q <= IDLE;
    end
  end
  assign ic_download_state = ~pend_q;
  assign v_inst_4word      = v_q;
  assign inst_4word        = out_q;
endmodule

// File: tb/tb_ic_download.sv
// tb_ic_download: directed checks of remote/local assembly, collision, drop and async reset.
module tb_ic_download;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         v_flit = 1'b0;
  logic [15:0]  flit = '0;
  logic [1:0]   ctrl = '0;
  logic         v_mem_rep = 1'b0;
  logic [127:0] mem_rep = '0;
  logic         ic_download_state, v_inst_4word;
  logic [127:0] inst_4word;
  int n_chk = 0;
  int n_fail = 0;

  localparam logic [15:0] HEAD_OK  = 16'h0700;
  localparam logic [15:0] HEAD_BAD = 16'h0600;
  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] DB = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  ic_download dut (
    .clk(clk), .rst(rst), .v_flit(v_flit), .flit(flit), .ctrl(ctrl),
    .v_mem_rep(v_mem_rep), .mem_rep(mem_rep),
    .ic_download_state(ic_download_state), .v_inst_4word(v_inst_4word),
    .inst_4word(inst_4word)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst && !ic_download_state && v_mem_rep) begin
      n_fail++;
      $error("FAIL proto: v_mem_rep while pending");
    end

  function automatic logic [127:0] mk(input logic [15:0] b);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = b + 16'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [15:0] f);
    v_flit = 1'b1;
    ctrl   = c;
    flit   = f;
    tick();
    v_flit = 1'b0;
    ctrl   = 2'b00;
  endtask

  task automatic bodies(input logic [15:0] b, input int k);
    for (int i = 0; i < k; i++) send(2'b10, b + 16'(i));
  endtask

  task automatic reply(input logic [15:0] b, input string tag);
    send(2'b01, HEAD_OK);
    bodies(b, 7);
    chk1({tag, "_pre"}, v_inst_4word, 1'b0);
    send(2'b11, b + 16'd7);
    chk1({tag, "_v"}, v_inst_4word, 1'b1);
    chkd({tag, "_d"}, inst_4word, mk(b));
    tick();
    chk1({tag, "_v_off"}, v_inst_4word, 1'b0);
    chkd({tag, "_hold"}, inst_4word, mk(b));
  endtask

  initial begin
    #2;
    chk1("rst_v", v_inst_4word, 1'b0);
    chkd("rst_d", inst_4word, '0);
    chk1("rst_st", ic_download_state, 1'b1);
    tick();
    rst = 1'b1;
    tick();

    send(2'b01, HEAD_OK);
    bodies(16'h0001, 7);
    send(2'b11, 16'h0008);
    chk1("rem_v", v_inst_4word, 1'b1);
    chkd("rem_d", inst_4word, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    tick();
    chk1("rem_v_off", v_inst_4word, 1'b0);

    v_mem_rep = 1'b1;
    mem_rep   = DB;
    tick();
    v_mem_rep = 1'b0;
    chk1("loc_v", v_inst_4word, 1'b1);
    chkd("loc_d", inst_4word, DB);
    chk1("loc_st", ic_download_state, 1'b1);
    tick();
    chk1("loc_v_off", v_inst_4word, 1'b0);
    chkd("loc_hold", inst_4word, DB);

    send(2'b01, HEAD_OK);
    bodies(16'h0011, 7);
    v_flit = 1'b1; ctrl = 2'b11; flit = 16'h0018;
    v_mem_rep = 1'b1; mem_rep = A5;
    tick();
    v_mem_rep = 1'b0;
    ctrl = 2'b01; flit = HEAD_OK;
    chk1("col1_v", v_inst_4word, 1'b1);
    chkd("col1_d", inst_4word, A5);
    chk1("col1_st", ic_download_state, 1'b0);
    tick();
    chk1("col2_v", v_inst_4word, 1'b1);
    chkd("col2_d", inst_4word, mk(16'h0011));
    chk1("col2_st", ic_download_state, 1'b1);
    tick();
    v_flit = 1'b0; ctrl = 2'b00;
    chk1("col3_v", v_inst_4word, 1'b0);
    bodies(16'h0021, 7);
    send(2'b11, 16'h0028);
    chk1("held_v", v_inst_4word, 1'b1);
    chkd("held_d", inst_4word, mk(16'h0021));
    tick();

    send(2'b01, HEAD_BAD);
    bodies(16'h00F1, 7);
    send(2'b11, 16'h00F8);
    chk1("bad_v", v_inst_4word, 1'b0);
    tick();
    chk1("bad_v2", v_inst_4word, 1'b0);
    chkd("bad_hold", inst_4word, mk(16'h0021));
    reply(16'h0031, "after_bad");

    send(2'b01, HEAD_OK);
    bodies(16'h0041, 3);
    send(2'b11, 16'h0044);
    chk1("short_v", v_inst_4word, 1'b0);
    tick();
    chk1("short_v2", v_inst_4word, 1'b0);

    send(2'b01, HEAD_OK);
    bodies(16'h0051, 8);
    send(2'b11, 16'h0059);
    chk1("long_v", v_inst_4word, 1'b0);
    tick();
    chk1("long_v2", v_inst_4word, 1'b0);
    reply(16'h0061, "after_long");

    send(2'b01, HEAD_OK);
    bodies(16'h0071, 4);
    #3 rst = 1'b0;
    #1;
    chk1("arst_v", v_inst_4word, 1'b0);
    chkd("arst_d", inst_4word, '0);
    chk1("arst_st", ic_download_state, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    bodies(16'h0081, 3);
    send(2'b11, 16'h0084);
    chk1("arst_idle_v", v_inst_4word, 1'b0);
    tick();
    chk1("arst_idle_v2", v_inst_4word, 1'b0);
    reply(16'h0091, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ic_download.md
Name: ic_download

Overview:
- Reply-side companion of the instruction cache: collects instruction-fill replies and presents one 128-bit cache block, `inst_4word`, with a single-cycle `v_inst_4word` strobe. The instruction cache consumes this strobe in its wait-reply state.
- Two sources:
  - a local-memory reply, delivered as one 128-bit beat;
  - a remote reply arriving from the ring as head + body flits, deserialised here.
- Sits between the ring ejection port / local memory and the instruction cache.

Parameters:
- FLIT_W, 16, ring flit width in bits.
- DATA_W, 128, cache block width; must equal NUM_DATA*FLIT_W.
- NUM_DATA, 8, data flits per remote reply (body flits plus tail flit).
- INST_REP_CMD, 5'b00111, command code of an instruction reply in head flit bits [12:8].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- v_flit  in  1  flit valid from ring ejection.
- flit  in  FLIT_W  flit payload.
- ctrl  in  2  flit type: 01 head, 10 body, 11 tail, 00 invalid.
- v_mem_rep  in  1  local-memory reply valid (one-cycle pulse).
- mem_rep  in  DATA_W  local-memory reply block.
- ic_download_state  out  1  1 = flit accepted this cycle; 0 = upstream must hold flit.
- v_inst_4word  out  1  one-cycle strobe; block valid.
- inst_4word  out  DATA_W  assembled block, word0 in [31:0].

Behaviour:
- Reset (rst low, asynchronous):
  - FSM enters IDLE; flit counter is 0; pending flag is 0.
  - `v_inst_4word` = 0, `inst_4word` = 0, `ic_download_state` = 1.
  - Any partially collected message is discarded.
- A flit is consumed only when `v_flit`=1 and `ic_download_state`=1.
- FSM states: IDLE, RECV, DROP.
  - IDLE, consumed head with `flit[12:8]`==INST_REP_CMD: go to RECV, counter = 0.
  - IDLE, consumed head with any other cmd: go to DROP.
  - IDLE, consumed body or tail flit: ignored; stay in IDLE.
  - RECV, consumed body: store the flit at slice [cnt*FLIT_W +: FLIT_W]; counter +1. If this was flit NUM_DATA (counter would reach 8), the message is malformed: go to DROP.
  - RECV, consumed tail with counter == NUM_DATA-1: store the flit in the top slice, complete the block, go to IDLE.
  - RECV, consumed tail with counter != NUM_DATA-1 (short message): discard with no output; go to IDLE.
  - RECV, consumed head: discard the partial block and restart as if in IDLE.
  - DROP: consume flits until a tail, then go to IDLE. No output.
- Output and latency:
  - Outputs are registered.
  - A completed remote block raises `v_inst_4word` the cycle after the tail is consumed.
  - A local reply raises `v_inst_4word` the cycle after `v_mem_rep`, with `inst_4word`=`mem_rep`.
  - `inst_4word` holds its last value when no strobe is active.
- Collision (remote completion and `v_mem_rep` in the same cycle):
  - The local reply is output first.
  - The remote block is latched in a pending register (pending=1) and output on the next cycle.
  - `ic_download_state` = 0 while pending=1, so no flit is consumed during that cycle.
  - A second `v_mem_rep` while pending=1 cannot occur, since the cache has only one outstanding miss. If it does occur, the pending block wins and the local beat is lost. The bench flags this as a protocol error.
- `v_inst_4word` is never high for two consecutive cycles unless the collision case occurs.
- Width rules:
  - Counter is clog2(NUM_DATA)+1 bits.
  - Flit slices are written in arrival order, lowest slice first.

Decomposition:
- Shared package (ring_pkg) holds:
  - flit type codes: FLIT_HEAD, FLIT_BODY, FLIT_TAIL;
  - command codes: INST_REP_CMD, with instreq_cmd alongside for the request side;
  - the head-flit cmd field position [12:8].
- No sub-module is needed; the flit deserialiser stays inline. The FSM and output mux are small enough for a single module.

Test Plan:
- Remote reply: head(cmd=00111), then flits 0x0001..0x0007 as body, then tail 0x0008 → one strobe the cycle after the tail, `inst_4word`=128'h0008_0007_0006_0005_0004_0003_0002_0001.
- Local reply: `v_mem_rep`=1, `mem_rep`=128'hDEADBEEF_...; → strobe next cycle with the same data. `ic_download_state` stays 1.
- Collision: tail consumed in the same cycle as `v_mem_rep`(128'hA5..A5) → cycle+1 outputs the A5 block; cycle+2 outputs the remote block; `ic_download_state`=0 during cycle+1. A flit held on the ring input is consumed at cycle+2.
- Wrong command: head cmd=00110 followed by 8 data flits → no strobe; FSM back to IDLE after the tail. An immediately following valid reply assembles correctly.
- Short message: head, 3 body, tail → no strobe. Nine data flits (the 8th marked body) → DROP until tail, no strobe.
- Reset mid-message: rst low after 4 body flits → outputs 0 immediately (asynchronous). After release, a complete reply produces the correct block, with no stale slices from the aborted message.
